// File: rtl/fht_input_loader_pkg.sv
// Shared constants, state encoding and bit-reversal helper for the FHT input loader.
package fht_input_loader_pkg;

    localparam int N_BIT  = 10;
    localparam int A_BIT  = 8;
    localparam int D_BIT  = 16;
    localparam int N_BANK = 4;

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        FLUSH   = 3'd1,
        START   = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4
    } state_e;

    // Reverses the low 'width' bits of v; bits at and above 'width' come back zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < width; i++) begin
            r[i] = v[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_in_addr_gen.sv
// Maps a natural-order sample index to its bit-reversed bank (one-hot) and bank address.
// Purely combinational; the low two reversed bits select the bank.
module fht_in_addr_gen #(
    parameter int N_BIT = fht_input_loader_pkg::N_BIT,
    parameter int A_BIT = fht_input_loader_pkg::A_BIT
) (
    input  logic [N_BIT-1:0] idx,
    output logic [3:0]       we_onehot,
    output logic [A_BIT-1:0] addr
);
    import fht_input_loader_pkg::*;

    logic [N_BIT-1:0] rev;

    always_comb begin
        rev       = N_BIT'(bit_rev(32'(idx), N_BIT));
        we_onehot = 4'b0001 << rev[1:0];
        addr      = rev[N_BIT-1:2];
    end

endmodule

// File: rtl/fht_input_loader.sv
// Loads one frame of time-ordered samples into four banks in bit-reversed order, then
// starts the FHT and waits for it to finish (rdy low then high) before taking a new frame.
module fht_input_loader #(
    parameter int D_BIT = fht_input_loader_pkg::D_BIT,
    parameter int A_BIT = fht_input_loader_pkg::A_BIT,
    parameter int N_BIT = fht_input_loader_pkg::N_BIT
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iVALID,
    input  logic [D_BIT-1:0] iDATA,
    output logic             oREADY,
    input  logic             iFHT_RDY,
    output logic [3:0]       oWE,
    output logic [A_BIT-1:0] oADDR,
    output logic [D_BIT-1:0] oDATA,
    output logic             oSTART,
    output logic             oBUSY
);
    import fht_input_loader_pkg::*;

    state_e           state;
    logic [N_BIT-1:0] idx;
    logic             accept;
    logic             last_sample;
    logic [3:0]       bank_we;
    logic [A_BIT-1:0] bank_addr;

    assign oREADY      = (state == LOAD) && iFHT_RDY;
    assign accept      = iVALID && oREADY;
    assign last_sample = (idx == {N_BIT{1'b1}});
    assign oSTART      = (state == START);
    assign oBUSY       = (state != LOAD);

    fht_in_addr_gen #(
        .N_BIT (N_BIT),
        .A_BIT (A_BIT)
    ) u_addr_gen (
        .idx       (idx),
        .we_onehot (bank_we),
        .addr      (bank_addr)
    );

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state <= LOAD;
            idx   <= '0;
            oWE   <= '0;
            oADDR <= '0;
            oDATA <= '0;
        end else begin
            oWE <= accept ? bank_we : 4'b0000;
            // Address and data hold their last value between writes.
            if (accept) begin
                oADDR <= bank_addr;
                oDATA <= iDATA;
                idx   <= idx + 1'b1;
            end
            case (state)
                LOAD:    if (accept && last_sample) state <= FLUSH;
                FLUSH:   state <= START;
                START:   state <= WAIT_LO;
                WAIT_LO: if (!iFHT_RDY) state <= WAIT_HI;
                WAIT_HI: begin
                    if (iFHT_RDY) begin
                        state <= LOAD;
                        idx   <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
